// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit.
//   req_valid_i / req_ready_o  : request handshake (funct3_i, op1_data_i, op2_data_i)
//   flush_i                    : abort any operation in flight
//   resp_valid_o / resp_ready_i: result handshake (result_o)
//   busy_o                     : unit not idle; pipeline stalls on it
// master = pipeline side, slave = muldiv_unit side.
interface muldiv_unit_if #(
  parameter int unsigned WD_SIZE = 32
);
  logic               req_valid_i;
  logic               req_ready_o;
  logic [2:0]         funct3_i;
  logic [WD_SIZE-1:0] op1_data_i;
  logic [WD_SIZE-1:0] op2_data_i;
  logic               flush_i;
  logic               resp_valid_o;
  logic               resp_ready_i;
  logic [WD_SIZE-1:0] result_o;
  logic               busy_o;

  modport master (
    output req_valid_i, funct3_i, op1_data_i, op2_data_i, flush_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, result_o, busy_o
  );

  modport slave (
    input  req_valid_i, funct3_i, op1_data_i, op2_data_i, flush_i, resp_ready_i,
    output req_ready_o, resp_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   clk     : core clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : muldiv_unit_if.slave (request, flush, response, busy)
// One shift-add (multiply, LSB-first) or restoring shift-subtract (divide,
// MSB-first) step per cycle on operand magnitudes, followed by one sign-fix
// cycle. Divide-by-zero and signed overflow complete straight from IDLE.
module muldiv_unit #(
  parameter int unsigned WD_SIZE  = 32,
  parameter int unsigned CNT_SIZE = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  muldiv_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_SIZE-1:0] CNT_LAST = CNT_SIZE'(WD_SIZE - 1);
  localparam logic [WD_SIZE-1:0]  MIN_NEG  = {1'b1, {(WD_SIZE-1){1'b0}}};

  logic [1:0]           state_q;
  logic [CNT_SIZE-1:0]  cnt_q;
  logic [2:0]           f3_q;
  logic                 neg_q;      // negate product / quotient
  logic                 neg_rem_q;  // remainder takes sign of op1
  logic [2*WD_SIZE-1:0] prod_q;     // {partial sum | remainder, multiplier | dividend/quotient}
  logic [WD_SIZE-1:0]   mcand_q;    // multiplicand or divisor magnitude
  logic [WD_SIZE-1:0]   result_q;

  // ---------------- operand preparation ----------------
  logic               op1_signed, op2_signed, op1_neg, op2_neg;
  logic [WD_SIZE-1:0] mag1, mag2;
  logic               is_div, div_zero, div_ovf, accept;
  logic [WD_SIZE-1:0] fast_result;

  always_comb begin
    op1_signed = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) ||
                 (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
    op2_signed = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b100) ||
                 (bus.funct3_i == 3'b110);
    op1_neg    = op1_signed & bus.op1_data_i[WD_SIZE-1];
    op2_neg    = op2_signed & bus.op2_data_i[WD_SIZE-1];
    mag1       = op1_neg ? -bus.op1_data_i : bus.op1_data_i;
    mag2       = op2_neg ? -bus.op2_data_i : bus.op2_data_i;
    is_div     = bus.funct3_i[2];
    div_zero   = is_div && (bus.op2_data_i == '0);
    div_ovf    = is_div && !bus.funct3_i[0] &&
                 (bus.op1_data_i == MIN_NEG) && (bus.op2_data_i == '1);
    if (div_zero)
      fast_result = bus.funct3_i[1] ? bus.op1_data_i : '1;
    else
      fast_result = bus.funct3_i[1] ? '0 : bus.op1_data_i;
    accept     = (state_q == S_IDLE) && bus.req_valid_i && !bus.flush_i;
  end

  // ---------------- iteration step ----------------
  logic [WD_SIZE:0]     mul_sum;
  logic [2*WD_SIZE-1:0] mul_next;
  logic [WD_SIZE:0]     div_tmp, div_diff;
  logic                 div_ge;
  logic [WD_SIZE-1:0]   div_rem;
  logic [2*WD_SIZE-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WD_SIZE-1:WD_SIZE]} +
               {1'b0, (prod_q[0] ? mcand_q : '0)};
    mul_next = {mul_sum, prod_q[WD_SIZE-1:1]};
    // Partial remainder stays below the divisor, so div_diff[WD_SIZE] is a clean borrow.
    div_tmp  = {prod_q[2*WD_SIZE-1:WD_SIZE], prod_q[WD_SIZE-1]};
    div_diff = div_tmp - {1'b0, mcand_q};
    div_ge   = !div_diff[WD_SIZE];
    div_rem  = div_ge ? div_diff[WD_SIZE-1:0] : div_tmp[WD_SIZE-1:0];
    div_next = {div_rem, prod_q[WD_SIZE-2:0], div_ge};
  end

  // ---------------- sign fix / result select ----------------
  logic [2*WD_SIZE-1:0] prod_fix;
  logic [WD_SIZE-1:0]   quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -prod_q[WD_SIZE-1:0] : prod_q[WD_SIZE-1:0];
    rem_fix  = neg_rem_q ? -prod_q[2*WD_SIZE-1:WD_SIZE] : prod_q[2*WD_SIZE-1:WD_SIZE];
    case (f3_q)
      3'b000:                 fix_result = prod_fix[WD_SIZE-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*WD_SIZE-1:WD_SIZE];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  // ---------------- sequencing ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      prod_q    <= '0;
      mcand_q   <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            f3_q      <= bus.funct3_i;
            neg_q     <= op1_neg ^ op2_neg;
            neg_rem_q <= op1_neg;
            if (div_zero || div_ovf) begin
              result_q <= fast_result;
              state_q  <= S_DONE;
            end else begin
              prod_q  <= {{WD_SIZE{1'b0}}, mag1};
              mcand_q <= mag2;
              cnt_q   <= '0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush_i) begin
            state_q <= S_IDLE;
          end else begin
            prod_q <= f3_q[2] ? div_next : mul_next;
            cnt_q  <= cnt_q + CNT_SIZE'(1);
            if (cnt_q == CNT_LAST) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.flush_i) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= fix_result;
            state_q  <= S_DONE;
          end
        end
        default: begin
          // Flush wins over a simultaneous handshake; either way we leave DONE.
          if (bus.flush_i || bus.resp_ready_i) state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = (state_q == S_IDLE);
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.resp_valid_o = (state_q == S_DONE);
  assign bus.result_o     = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit (WD_SIZE=32). Latency is
// counted in rising edges with the accept edge as edge 1.
module tb_muldiv_unit;

  logic clk;
  logic reset_n;
  int   tests;
  int   failed;

  muldiv_unit_if #(.WD_SIZE(32)) mif ();

  muldiv_unit #(.WD_SIZE(32), .CNT_SIZE(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response, check latency, result,
  // busy over the whole operation, and return to IDLE after the handshake.
  task automatic op_check(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
    int   edges;
    logic busy_ok;
    mif.req_valid_i = 1'b1;
    mif.funct3_i    = f3;
    mif.op1_data_i  = a;
    mif.op2_data_i  = b;
    @(posedge clk); #1;
    mif.req_valid_i = 1'b0;
    mif.op1_data_i  = 32'h0;
    mif.op2_data_i  = 32'h0;
    edges   = 1;
    busy_ok = mif.busy_o;
    while (!mif.resp_valid_o && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      busy_ok &= mif.busy_o;
    end
    chk({tag, "_lat"},  edges, exp_lat);
    chk({tag, "_res"},  mif.result_o, exp);
    chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {31'b0, mif.req_ready_o}, 32'd1);
  endtask

  initial begin
    int   edges;
    logic stable;
    tests  = 0;
    failed = 0;
    reset_n          = 1'b0;
    mif.req_valid_i  = 1'b0;
    mif.funct3_i     = 3'b000;
    mif.op1_data_i   = 32'h0;
    mif.op2_data_i   = 32'h0;
    mif.flush_i      = 1'b0;
    mif.resp_ready_i = 1'b1;

    #1;
    chk("rst_req_ready",  {31'b0, mif.req_ready_o},  32'd1);
    chk("rst_resp_valid", {31'b0, mif.resp_valid_o}, 32'd0);
    chk("rst_busy",       {31'b0, mif.busy_o},       32'd0);
    chk("rst_result",     mif.result_o,              32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Normal path: accept edge + 32 iterations + FIX -> valid at edge 34.
    op_check("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    op_check("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    op_check("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    op_check("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    op_check("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    op_check("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    op_check("divu",   3'b101, 32'd100,      32'd7,        32'd14,       34);
    op_check("remu",   3'b111, 32'd100,      32'd7,        32'd2,        34);

    // Fast paths: valid right after the accept edge.
    op_check("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    op_check("remu0",  3'b111, 32'd5,        32'd0,        32'd5,        1);
    op_check("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    op_check("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);

    // Backpressure in DONE.
    mif.resp_ready_i = 1'b0;
    mif.req_valid_i  = 1'b1;
    mif.funct3_i     = 3'b101;
    mif.op1_data_i   = 32'd100;
    mif.op2_data_i   = 32'd7;
    @(posedge clk); #1;
    mif.req_valid_i = 1'b0;
    edges = 1;
    while (!mif.resp_valid_o && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("bp_lat", edges, 34);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!(mif.resp_valid_o === 1'b1 && mif.result_o === 32'd14 &&
            mif.req_ready_o === 1'b0)) stable = 1'b0;
    end
    chk("bp_stable", {31'b0, stable}, 32'd1);
    mif.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", {31'b0, mif.req_ready_o},  32'd1);
    chk("bp_idle_valid", {31'b0, mif.resp_valid_o}, 32'd0);
    // Next request on the very following edge.
    op_check("bp_next", 3'b000, 32'd3, 32'd5, 32'd15, 34);

    // Flush at CALC iteration 10.
    mif.req_valid_i = 1'b1;
    mif.funct3_i    = 3'b000;
    mif.op1_data_i  = 32'd9;
    mif.op2_data_i  = 32'd9;
    @(posedge clk); #1;
    mif.req_valid_i = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("fl_calc_busy", {31'b0, mif.busy_o}, 32'd1);
    mif.flush_i = 1'b1;
    @(posedge clk); #1;
    mif.flush_i = 1'b0;
    chk("fl_calc_idle",  {31'b0, mif.busy_o},       32'd0);
    chk("fl_calc_ready", {31'b0, mif.req_ready_o},  32'd1);
    stable = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (mif.resp_valid_o !== 1'b0) stable = 1'b0;
    end
    chk("fl_calc_noresp", {31'b0, stable}, 32'd0 + 32'd1);

    // Flush together with resp_ready in DONE.
    mif.resp_ready_i = 1'b0;
    mif.req_valid_i  = 1'b1;
    mif.funct3_i     = 3'b111;
    mif.op1_data_i   = 32'd100;
    mif.op2_data_i   = 32'd7;
    @(posedge clk); #1;
    mif.req_valid_i = 1'b0;
    edges = 1;
    while (!mif.resp_valid_o && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("fl_done_lat", edges, 34);
    chk("fl_done_res", mif.result_o, 32'd2);
    mif.flush_i      = 1'b1;
    mif.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("fl_done_valid", {31'b0, mif.resp_valid_o}, 32'd0);
    chk("fl_done_ready", {31'b0, mif.req_ready_o},  32'd1);

    // Flush in IDLE blocks acceptance.
    mif.req_valid_i = 1'b1;
    mif.funct3_i    = 3'b000;
    mif.op1_data_i  = 32'd2;
    mif.op2_data_i  = 32'd2;
    @(posedge clk); #1;
    chk("fl_idle_block", {31'b0, mif.busy_o}, 32'd0);
    mif.flush_i     = 1'b0;
    mif.req_valid_i = 1'b0;

    // Asynchronous reset mid-CALC.
    mif.req_valid_i = 1'b1;
    mif.funct3_i    = 3'b011;
    mif.op1_data_i  = 32'hFFFFFFFF;
    mif.op2_data_i  = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mif.req_valid_i = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("ar_pre_busy", {31'b0, mif.busy_o}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_busy",   {31'b0, mif.busy_o},       32'd0);
    chk("ar_valid",  {31'b0, mif.resp_valid_o}, 32'd0);
    chk("ar_ready",  {31'b0, mif.req_ready_o},  32'd1);
    chk("ar_result", mif.result_o,              32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    stable = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (mif.resp_valid_o !== 1'b0 || mif.busy_o !== 1'b0) stable = 1'b0;
    end
    chk("ar_noresp", {31'b0, stable}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit with its own sequencing FSM. It sits beside the single-cycle ALU in the execute stage.
- The decoder routes OPCODE_OP instructions with funct7 = 0000001 here instead of to the ALU.
- It holds operands, runs one shift-add or shift-subtract step per cycle, then applies sign correction.
- It returns the result over a valid/ready handshake; the pipeline stalls on busy_o.

Parameters:
- WD_SIZE, 32, operand/result width; must be even and ≥ 4.
- CNT_SIZE, 6, iteration counter width; must satisfy 2^CNT_SIZE > WD_SIZE.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  operation request.
- req_ready_o  out  1  unit can accept a request (IDLE only).
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1_data_i  in  WD_SIZE  rs1 value.
- op2_data_i  in  WD_SIZE  rs2 value.
- flush_i  in  1  abort current operation (branch/jump redirect).
- resp_valid_o  out  1  result_o valid.
- resp_ready_i  in  1  consumer takes result.
- result_o  out  WD_SIZE  operation result.
- busy_o  out  1  operation in flight or result unconsumed (state ≠ IDLE).

Behaviour:
- Reset (async, reset_n low): state=IDLE, counter=0, all operand/accumulator registers 0. Outputs: req_ready_o=1, resp_valid_o=0, busy_o=0, result_o=0.
- FSM states: IDLE, CALC, FIX, DONE.
- Accept: a request is taken on a rising edge with req_valid_i & req_ready_o & !flush_i. funct3_i and operands are latched; the unit does not need them held afterwards.
- Operand prep at accept:
  - Signed operands are converted to magnitudes; sign flags are recorded.
  - MULH: both operands signed. MULHSU: op1 signed, op2 unsigned. MULHU, DIVU, REMU: unsigned.
  - MUL: low-word result is sign-agnostic and is computed unsigned.
- Fast paths (from IDLE, next state DONE, result registered at accept):
  - Divide by zero (op2=0, funct3=1xx): DIV/DIVU return all-ones; REM/REMU return op1.
  - Signed overflow (DIV/REM, op1=1 followed by WD_SIZE-1 zeros, op2=all-ones): DIV returns op1; REM returns 0.
- Normal path: IDLE -> CALC, counter=0.
  - CALC performs one iteration per cycle for exactly WD_SIZE cycles (counter 0..WD_SIZE-1), then moves to FIX.
  - Multiply: 2·WD_SIZE-bit shift-add, LSB-first.
  - Divide: restoring, MSB-first; the quotient bit is set when the partial remainder is ≥ the divisor.
- FIX (1 cycle):
  - Multiply: negate the product if sign(op1) XOR sign(op2), for the signed variants.
  - DIV: negate the quotient if the signs differ.
  - REM: remainder takes the sign of op1.
  - Select the result: MUL low word; MULH/MULHSU/MULHU high word; DIV/DIVU quotient; REM/REMU remainder.
  - FIX -> DONE.
- Latency:
  - resp_valid_o rises WD_SIZE+2 edges after the accept edge (34 for WD_SIZE=32).
  - Fast path: 1 edge after accept.
- DONE:
  - resp_valid_o=1; result_o is stable and held until resp_ready_i.
  - When resp_valid_o & resp_ready_i at an edge: go to IDLE, resp_valid_o=0.
  - No back-to-back overlap: the next request is accepted no earlier than the cycle after the handshake, because req_ready_o is combinationally tied to state==IDLE.
- result_o: holds its last value outside DONE; it is valid only while resp_valid_o=1.
- Flush:
  - flush_i=1 in CALC, FIX or DONE: next state IDLE, the result is discarded, resp_valid_o=0 next cycle.
  - flush_i has priority over a resp_ready_i handshake in the same cycle; the flushed result counts as not delivered.
  - flush_i in IDLE blocks acceptance.
- busy_o = (state ≠ IDLE); it is combinational from the state register.
- Reset mid-operation: immediate return to the reset values; no response is produced.

Test Plan:
- MUL 7 × -3 (op2=0xFFFFFFFD), resp_ready_i=1 -> resp_valid_o at edge 34 after accept, result 0xFFFFFFEB; busy_o high for the whole 34 cycles.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast paths, each with resp_valid_o 1 edge after accept:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Backpressure: hold resp_ready_i=0 for 10 cycles in DONE -> resp_valid_o and result_o stay stable and req_ready_o stays 0; one cycle of resp_ready_i -> IDLE next edge, and a new request is accepted on the following edge.
- Abort cases:
  - flush_i at CALC iteration 10 -> IDLE next edge, no resp_valid_o.
  - flush_i together with resp_ready_i in DONE -> IDLE, and the result counts as not delivered.
  - reset_n low mid-CALC -> outputs reach reset values asynchronously, before the next edge.
